pu_msp430_dbg_hwbrk_seq: RTL and testbench

//  Parametrised hardware break/watch-point unit for the MSP430 debug block: NCH independent channels.

---
 rtl/pu_msp430_dbg_hwbrk_pkg.sv | 52 +++++
 rtl/pu_msp430_dbg_hwbrk_chan.sv | 103 ++++++++++
 rtl/pu_msp430_dbg_hwbrk_seq.sv | 108 ++++++++++
 tb/tb_pu_msp430_dbg_hwbrk_seq.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_msp430_dbg_hwbrk_pkg.sv
// Shared constants and types for the MSP430 debug hardware break/watch-point unit.
// Register layout: channel k occupies indices 5k..5k+4, SEQ_CTL follows the last channel.
package pu_msp430_dbg_hwbrk_pkg;

    localparam int REGS_PER_CH = 5;

    localparam logic [2:0] REG_CTL   = 3'd0;
    localparam logic [2:0] REG_STAT  = 3'd1;
    localparam logic [2:0] REG_ADDR0 = 3'd2;
    localparam logic [2:0] REG_ADDR1 = 3'd3;
    localparam logic [2:0] REG_CNT   = 3'd4;

    localparam int CTL_MODE_RD  = 0;
    localparam int CTL_MODE_WR  = 1;
    localparam int CTL_BREAK_EN = 2;
    localparam int CTL_INST_EN  = 3;
    localparam int CTL_RANGE    = 4;
    localparam int CTL_CNT_EN   = 5;

    localparam int STAT_A0_RD  = 0;
    localparam int STAT_A0_WR  = 1;
    localparam int STAT_A1_RD  = 2;
    localparam int STAT_A1_WR  = 3;
    localparam int STAT_RNG_RD = 4;
    localparam int STAT_RNG_WR = 5;

    typedef enum logic {
        SEQ_OFF   = 1'b0,
        SEQ_STAGE = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic cnt_en;
        logic rng;
        logic inst_en;
        logic break_en;
        logic mode_wr;
        logic mode_rd;
    } ctl_t;

    function automatic ctl_t ctl_from_word(input logic [15:0] w);
        ctl_t c;
        c.cnt_en   = w[CTL_CNT_EN];
        c.rng      = w[CTL_RANGE];
        c.inst_en  = w[CTL_INST_EN];
        c.break_en = w[CTL_BREAK_EN];
        c.mode_wr  = w[CTL_MODE_WR];
        c.mode_rd  = w[CTL_MODE_RD];
        return c;
    endfunction

endpackage

// File: rtl/pu_msp430_dbg_hwbrk_chan.sv
// One break/watch-point channel: CTL/STAT/ADDR0/ADDR1/CNT registers, address comparators
// and pass counter. `allow` lets the sequencer freeze a channel (no fire, counter holds).
module pu_msp430_dbg_hwbrk_chan
    import pu_msp430_dbg_hwbrk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              dbg_clk,
    input  logic              dbg_rst,
    input  logic              reg_wr,
    input  logic [2:0]        reg_off,
    input  logic [15:0]       dbg_din,
    input  logic              decode_noirq,
    input  logic [15:0]       eu_mab,
    input  logic              eu_mb_en,
    input  logic [1:0]        eu_mb_wr,
    input  logic [15:0]       pc,
    input  logic              allow,
    output logic              fire,
    output logic              brk,
    output logic [5:0]        stat,
    output logic [15:0]       rd_data
);

    ctl_t             ctl;
    logic [15:0]      addr0;
    logic [15:0]      addr1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_cur;

    logic [15:0] a;
    logic        acc_rd;
    logic        acc_wr;
    logic        eq0;
    logic        eq1;
    logic        in_rng;
    logic        evt;
    logic [5:0]  hit;
    logic        wr_ctl;
    logic        wr_stat;
    logic        wr_cnt;

    always_comb begin
        a      = ctl.inst_en ? pc : eu_mab;
        acc_rd = (ctl.inst_en ? decode_noirq : (eu_mb_en & ~|eu_mb_wr)) & ctl.mode_rd;
        acc_wr = ~ctl.inst_en & eu_mb_en & (|eu_mb_wr) & ctl.mode_wr;
        eq0    = ~ctl.rng & (a == addr0);
        eq1    = ~ctl.rng & (a == addr1);
        // An inverted window (addr0 > addr1) fails one of the two bounds and never matches.
        in_rng = ctl.rng & (a >= addr0) & (a <= addr1);
        hit              = '0;
        hit[STAT_A0_RD]  = eq0 & acc_rd;
        hit[STAT_A0_WR]  = eq0 & acc_wr;
        hit[STAT_A1_RD]  = eq1 & acc_rd;
        hit[STAT_A1_WR]  = eq1 & acc_wr;
        hit[STAT_RNG_RD] = in_rng & acc_rd;
        hit[STAT_RNG_WR] = in_rng & acc_wr;
        evt  = allow & (|hit);
        fire = evt & (~ctl.cnt_en | (cnt_cur == '0));
        brk  = fire & ctl.break_en;
    end

    assign wr_ctl  = reg_wr & (reg_off == REG_CTL);
    assign wr_stat = reg_wr & (reg_off == REG_STAT);
    assign wr_cnt  = reg_wr & (reg_off == REG_CNT);

    always_ff @(posedge dbg_clk) begin
        if (dbg_rst) begin
            ctl     <= '0;
            stat    <= '0;
            addr0   <= '0;
            addr1   <= '0;
            cnt     <= '0;
            cnt_cur <= '0;
        end else begin
            if (wr_ctl)                              ctl   <= ctl_from_word(dbg_din);
            if (reg_wr && (reg_off == REG_ADDR0))    addr0 <= dbg_din;
            if (reg_wr && (reg_off == REG_ADDR1))    addr1 <= dbg_din;
            if (wr_cnt)                              cnt   <= dbg_din[CNT_W-1:0];
            // A new hit outranks a same-cycle write-1-to-clear.
            stat <= (stat & ~(wr_stat ? dbg_din[5:0] : 6'h00)) | (fire ? hit : 6'h00);
            if (wr_cnt)
                cnt_cur <= dbg_din[CNT_W-1:0];
            else if (wr_ctl)
                cnt_cur <= cnt;
            else if (evt && ctl.cnt_en)
                cnt_cur <= (cnt_cur == '0) ? cnt : cnt_cur - CNT_W'(1);
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_off)
            REG_CTL:   rd_data = {10'h000, ctl};
            REG_STAT:  rd_data = {10'h000, stat};
            REG_ADDR0: rd_data = addr0;
            REG_ADDR1: rd_data = addr1;
            REG_CNT:   rd_data = 16'(cnt_cur);
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: rtl/pu_msp430_dbg_hwbrk_seq.sv
// NCH-channel hardware break/watch-point unit: register decode, read mux, halt OR.
// Define HWBRK_SEQ_EN to build the ordered-hit sequencer behind SEQ_CTL.
module pu_msp430_dbg_hwbrk_seq
    import pu_msp430_dbg_hwbrk_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int CNT_W = 8,
    localparam int AW    = $clog2(5*NCH+1)
) (
    input  logic            dbg_clk,
    input  logic            dbg_rst,
    input  logic [AW-1:0]   brk_reg_addr,
    input  logic            brk_reg_rd,
    input  logic            brk_reg_wr,
    input  logic [15:0]     dbg_din,
    input  logic            decode_noirq,
    input  logic [15:0]     eu_mab,
    input  logic            eu_mb_en,
    input  logic [1:0]      eu_mb_wr,
    input  logic [15:0]     pc,
    output logic            brk_halt,
    output logic            brk_pnd,
    output logic [15:0]     brk_dout,
    output logic [NCH-1:0]  brk_chan_hit
);

    localparam int SEQ_IDX = REGS_PER_CH*NCH;

    logic [NCH-1:0]        ch_sel;
    logic [NCH-1:0]        allow;
    logic [NCH-1:0]        fire;
    logic [NCH-1:0]        brk;
    logic [NCH-1:0][2:0]   ch_off;
    logic [NCH-1:0][5:0]   ch_stat;
    logic [NCH-1:0][15:0]  ch_rd;
    logic                  seq_sel;
    logic [15:0]           seq_rd;

    assign seq_sel = (32'(brk_reg_addr) == SEQ_IDX);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam int BASE = REGS_PER_CH*k;
        assign ch_sel[k] = (32'(brk_reg_addr) >= BASE) && (32'(brk_reg_addr) < BASE + REGS_PER_CH);
        assign ch_off[k] = 3'(32'(brk_reg_addr) - BASE);

        pu_msp430_dbg_hwbrk_chan #(.CNT_W(CNT_W)) u_chan (
            .dbg_clk      (dbg_clk),
            .dbg_rst      (dbg_rst),
            .reg_wr       (brk_reg_wr & ch_sel[k]),
            .reg_off      (ch_off[k]),
            .dbg_din      (dbg_din),
            .decode_noirq (decode_noirq),
            .eu_mab       (eu_mab),
            .eu_mb_en     (eu_mb_en),
            .eu_mb_wr     (eu_mb_wr),
            .pc           (pc),
            .allow        (allow[k]),
            .fire         (fire[k]),
            .brk          (brk[k]),
            .stat         (ch_stat[k]),
            .rd_data      (ch_rd[k])
        );
    end

`ifdef HWBRK_SEQ_EN
    seq_state_t seq_state;
    logic [3:0] stage;

    always_ff @(posedge dbg_clk) begin
        if (dbg_rst) begin
            seq_state <= SEQ_OFF;
            stage     <= '0;
        end else if (brk_reg_wr && seq_sel) begin
            seq_state <= dbg_din[0] ? SEQ_STAGE : SEQ_OFF;
            stage     <= '0;
        end else if (seq_state == SEQ_STAGE && |fire) begin
            stage <= (stage == 4'(NCH-1)) ? 4'h0 : stage + 4'h1;
        end
    end

    always_comb begin
        allow = '0;
        for (int k = 0; k < NCH; k++)
            allow[k] = (seq_state == SEQ_OFF) || (stage == 4'(k));
    end

    // Only the stage channel can fire, so in sequence mode a halt means the last link closed.
    assign brk_halt = (seq_state == SEQ_OFF) ? |brk : ((stage == 4'(NCH-1)) & |brk);
    assign seq_rd   = {4'h0, stage, 7'h00, seq_state == SEQ_STAGE};
`else
    assign allow    = '1;
    assign brk_halt = |brk;
    assign seq_rd   = '0;
`endif

    always_comb begin
        brk_dout = '0;
        if (brk_reg_rd) begin
            for (int k = 0; k < NCH; k++)
                if (ch_sel[k]) brk_dout = ch_rd[k];
            if (seq_sel) brk_dout = seq_rd;
        end
    end

    assign brk_pnd      = |ch_stat;
    assign brk_chan_hit = fire;

endmodule

// File: tb/tb_pu_msp430_dbg_hwbrk_seq.sv
// Bench for pu_msp430_dbg_hwbrk_seq: directed vector table, hand sequences, then random
// traffic against a register-level reference model.
module tb_pu_msp430_dbg_hwbrk_seq;

    localparam int NCH = 4;
    localparam int AW  = $clog2(5*NCH+1);
`ifdef HWBRK_SEQ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic            dbg_clk = 1'b0;
    logic            dbg_rst;
    logic [AW-1:0]   brk_reg_addr;
    logic            brk_reg_rd;
    logic            brk_reg_wr;
    logic [15:0]     dbg_din;
    logic            decode_noirq;
    logic [15:0]     eu_mab;
    logic            eu_mb_en;
    logic [1:0]      eu_mb_wr;
    logic [15:0]     pc;
    logic            brk_halt;
    logic            brk_pnd;
    logic [15:0]     brk_dout;
    logic [NCH-1:0]  brk_chan_hit;

    pu_msp430_dbg_hwbrk_seq #(.NCH(NCH), .CNT_W(8)) dut (
        .dbg_clk(dbg_clk), .dbg_rst(dbg_rst), .brk_reg_addr(brk_reg_addr),
        .brk_reg_rd(brk_reg_rd), .brk_reg_wr(brk_reg_wr), .dbg_din(dbg_din),
        .decode_noirq(decode_noirq), .eu_mab(eu_mab), .eu_mb_en(eu_mb_en),
        .eu_mb_wr(eu_mb_wr), .pc(pc), .brk_halt(brk_halt), .brk_pnd(brk_pnd),
        .brk_dout(brk_dout), .brk_chan_hit(brk_chan_hit)
    );

    always #5 dbg_clk = ~dbg_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        brk_reg_wr = 0; brk_reg_rd = 0; brk_reg_addr = '0; dbg_din = '0;
        decode_noirq = 0; pc = '0; eu_mb_en = 0; eu_mb_wr = '0; eu_mab = '0;
    endtask

    task automatic cyc();
        @(posedge dbg_clk); #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        brk_reg_wr = 1; brk_reg_addr = AW'(a); dbg_din = d;
        cyc();
        brk_reg_wr = 0;
    endtask

    task automatic rd_chk(input string n, input int a, input logic [15:0] exp);
        brk_reg_rd = 1; brk_reg_addr = AW'(a);
        #1 check(n, 32'(brk_dout), 32'(exp));
        brk_reg_rd = 0;
        cyc();
    endtask

    task automatic pc_hit(input string n, input logic [15:0] p, input bit exp_halt);
        decode_noirq = 1; pc = p;
        #1 check(n, 32'(brk_halt), 32'(exp_halt));
        cyc();
        decode_noirq = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        bit          wr;
        bit          rd;
        int          addr;
        logic [15:0] din;
        bit          dec;
        logic [15:0] pc;
        bit          en;
        logic [1:0]  ewr;
        logic [15:0] mab;
        bit          halt;
        bit          chk;
        logic [15:0] dout;
    } vec_t;

    function automatic vec_t blank(input string n);
        vec_t v;
        v.name = n; v.wr = 0; v.rd = 0; v.addr = 0; v.din = '0; v.dec = 0; v.pc = '0;
        v.en = 0; v.ewr = '0; v.mab = '0; v.halt = 0; v.chk = 0; v.dout = '0;
        return v;
    endfunction
    function automatic vec_t V_WR(input int a, input logic [15:0] d);
        vec_t v = blank("wr");
        v.wr = 1; v.addr = a; v.din = d;
        return v;
    endfunction
    function automatic vec_t V_RD(input string n, input int a, input logic [15:0] e);
        vec_t v = blank(n);
        v.rd = 1; v.addr = a; v.chk = 1; v.dout = e;
        return v;
    endfunction
    function automatic vec_t V_PC(input string n, input logic [15:0] p, input bit h);
        vec_t v = blank(n);
        v.dec = 1; v.pc = p; v.halt = h;
        return v;
    endfunction
    function automatic vec_t V_EU(input string n, input logic [1:0] w, input logic [15:0] m, input bit h);
        vec_t v = blank(n);
        v.en = 1; v.ewr = w; v.mab = m; v.halt = h;
        return v;
    endfunction

    vec_t vecs[$];

    // ---------------- reference model ----------------
    int unsigned m_ctl[NCH], m_stat[NCH], m_a0[NCH], m_a1[NCH], m_cnt[NCH], m_cur[NCH];
    int unsigned m_set[NCH];
    bit          m_ev[NCH], m_fire[NCH];
    bit          m_seq_en;
    int unsigned m_stage;
    bit             e_halt, e_pnd;
    logic [NCH-1:0] e_hit;
    logic [15:0]    e_dout;

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_ctl[k] = 0; m_stat[k] = 0; m_a0[k] = 0; m_a1[k] = 0; m_cnt[k] = 0; m_cur[k] = 0;
        end
        m_seq_en = 0; m_stage = 0;
    endtask

    task automatic model_comb();
        int unsigned a, s, idx;
        bit seq_on, rda, wra;
        logic [5:0] c;
        seq_on = SEQ && m_seq_en;
        e_halt = 0; e_hit = '0; e_pnd = 0; e_dout = '0;
        for (int k = 0; k < NCH; k++) begin
            c   = 6'(m_ctl[k]);
            a   = c[3] ? pc : eu_mab;
            rda = (c[3] ? decode_noirq : (eu_mb_en && eu_mb_wr == 0)) && c[0];
            wra = !c[3] && eu_mb_en && eu_mb_wr != 0 && c[1];
            s = 0;
            if (c[4]) begin
                if (a >= m_a0[k] && a <= m_a1[k]) s = (rda ? 16 : 0) + (wra ? 32 : 0);
            end else begin
                if (a == m_a0[k]) s += (rda ? 1 : 0) + (wra ? 2 : 0);
                if (a == m_a1[k]) s += (rda ? 4 : 0) + (wra ? 8 : 0);
            end
            m_set[k]  = s;
            m_ev[k]   = (s != 0) && (!seq_on || m_stage == k);
            m_fire[k] = m_ev[k] && (!c[5] || m_cur[k] == 0);
            e_hit[k]  = m_fire[k];
            if (m_fire[k] && c[2] && (!seq_on || k == NCH-1)) e_halt = 1;
            if (m_stat[k] != 0) e_pnd = 1;
        end
        if (brk_reg_rd) begin
            idx = brk_reg_addr;
            if (idx < 5*NCH) begin
                case (idx % 5)
                    0: e_dout = 16'(m_ctl[idx/5]);
                    1: e_dout = 16'(m_stat[idx/5]);
                    2: e_dout = 16'(m_a0[idx/5]);
                    3: e_dout = 16'(m_a1[idx/5]);
                    default: e_dout = 16'(m_cur[idx/5]);
                endcase
            end else if (SEQ && idx == 5*NCH) begin
                e_dout = 16'((m_stage << 8) | m_seq_en);
            end
        end
    endtask

    task automatic model_clk();
        int unsigned idx, off, d;
        bit wrk, any_fire;
        idx = brk_reg_addr; off = idx % 5; d = dbg_din; any_fire = 0;
        for (int k = 0; k < NCH; k++) begin
            wrk = brk_reg_wr && idx < 5*NCH && idx/5 == k;
            if (m_fire[k]) any_fire = 1;
            if (wrk && off == 1) m_stat[k] &= ~(d & 63);
            if (m_fire[k]) m_stat[k] |= m_set[k];
            if (m_ev[k] && m_ctl[k][5]) m_cur[k] = (m_cur[k] == 0) ? m_cnt[k] : m_cur[k] - 1;
            if (wrk) begin
                case (off)
                    0: begin m_ctl[k] = d & 63; m_cur[k] = m_cnt[k]; end
                    2: m_a0[k] = d;
                    3: m_a1[k] = d;
                    4: begin m_cnt[k] = d & 255; m_cur[k] = d & 255; end
                    default: ;
                endcase
            end
        end
        if (SEQ) begin
            if (brk_reg_wr && idx == 5*NCH) begin
                m_seq_en = d[0]; m_stage = 0;
            end else if (m_seq_en && any_fire) begin
                m_stage = (m_stage == NCH-1) ? 0 : m_stage + 1;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wa;
        idle();
        dbg_rst = 1;
        cyc(); cyc();
        brk_reg_rd = 1; brk_reg_addr = AW'(2);
        #1;
        check("rst_halt", 32'(brk_halt), 0);
        check("rst_pnd",  32'(brk_pnd), 0);
        check("rst_hit",  32'(brk_chan_hit), 0);
        check("rst_dout", 32'(brk_dout), 0);
        idle();
        dbg_rst = 0;
        cyc();

        // T1: single-address instruction break
        vecs.push_back(V_WR(2, 16'h4400));
        vecs.push_back(V_WR(0, 16'h000D));
        vecs.push_back(V_RD("ctl0", 0, 16'h000D));
        vecs.push_back(V_RD("addr0", 2, 16'h4400));
        vecs.push_back(V_PC("t1_hit", 16'h4400, 1));
        vecs.push_back(V_RD("t1_stat", 1, 16'h0001));
        vecs.push_back(V_WR(1, 16'h0001));
        vecs.push_back(V_RD("t1_clr", 1, 16'h0000));
        vecs.push_back(V_PC("t1_miss", 16'h4401, 0));
        // T2: inclusive data-write window
        vecs.push_back(V_WR(7, 16'h0200));
        vecs.push_back(V_WR(8, 16'h020F));
        vecs.push_back(V_WR(5, 16'h0016));
        vecs.push_back(V_EU("t2_wr_hi", 2'b11, 16'h020F, 1));
        vecs.push_back(V_RD("t2_stat", 6, 16'h0020));
        vecs.push_back(V_WR(6, 16'h0020));
        vecs.push_back(V_EU("t2_wr_out", 2'b01, 16'h0210, 0));
        vecs.push_back(V_EU("t2_rd_in", 2'b00, 16'h0205, 0));
        vecs.push_back(V_EU("t2_wr_lo", 2'b10, 16'h0200, 1));
        vecs.push_back(V_WR(6, 16'h003F));
        vecs.push_back(V_RD("t2_clr", 6, 16'h0000));
        vecs.push_back(V_WR(7, 16'h0300));
        vecs.push_back(V_EU("t2_inv_a", 2'b11, 16'h0300, 0));
        vecs.push_back(V_EU("t2_inv_b", 2'b11, 16'h020F, 0));
        vecs.push_back(V_WR(5, 16'h0000));
        // T3: pass counter
        vecs.push_back(V_WR(4, 16'h0002));
        vecs.push_back(V_WR(0, 16'h002D));
        vecs.push_back(V_RD("t3_cnt_a", 4, 16'h0002));
        vecs.push_back(V_PC("t3_pass1", 16'h4400, 0));
        vecs.push_back(V_RD("t3_cnt_b", 4, 16'h0001));
        vecs.push_back(V_PC("t3_pass2", 16'h4400, 0));
        vecs.push_back(V_RD("t3_cnt_c", 4, 16'h0000));
        vecs.push_back(V_PC("t3_fire", 16'h4400, 1));
        vecs.push_back(V_RD("t3_cnt_d", 4, 16'h0002));
        vecs.push_back(V_RD("t3_stat", 1, 16'h0001));
        vecs.push_back(V_WR(1, 16'h0001));
        vecs.push_back(V_WR(0, 16'h0000));
        // read boundaries
        vecs.push_back(V_RD("seq_idle", 20, 16'h0000));
        vecs.push_back(V_RD("oor_21", 21, 16'h0000));
        vecs.push_back(V_RD("oor_31", 31, 16'h0000));
        begin
            vec_t v = blank("no_rd_strobe");
            v.addr = 2; v.chk = 1; v.dout = 16'h0000;
            vecs.push_back(v);
        end

        foreach (vecs[i]) begin
            brk_reg_wr = vecs[i].wr; brk_reg_rd = vecs[i].rd; brk_reg_addr = AW'(vecs[i].addr);
            dbg_din = vecs[i].din; decode_noirq = vecs[i].dec; pc = vecs[i].pc;
            eu_mb_en = vecs[i].en; eu_mb_wr = vecs[i].ewr; eu_mab = vecs[i].mab;
            #1;
            check({vecs[i].name, "_halt"}, 32'(brk_halt), 32'(vecs[i].halt));
            if (vecs[i].chk) check(vecs[i].name, 32'(brk_dout), 32'(vecs[i].dout));
            cyc();
            idle();
        end

        // T5: set beats clear, CNT write beats decrement
        wr(12, 16'h1234); wr(10, 16'h0001);
        eu_mb_en = 1; eu_mb_wr = 2'b00; eu_mab = 16'h1234;
        #1 check("t5_hit", 32'(brk_chan_hit), 32'h4);
        cyc(); idle();
        check("t5_pnd", 32'(brk_pnd), 1);
        rd_chk("t5_stat", 11, 16'h0001);
        eu_mb_en = 1; eu_mab = 16'h1234;
        wr(11, 16'h0001);
        idle();
        rd_chk("t5_set_wins", 11, 16'h0001);
        wr(11, 16'h0001);
        rd_chk("t5_clr", 11, 16'h0000);
        check("t5_pnd_clr", 32'(brk_pnd), 0);
        wr(14, 16'h0003); wr(10, 16'h0021);
        eu_mb_en = 1; eu_mab = 16'h1234;
        #1 check("t5_cnt_nofire", 32'(brk_chan_hit), 0);
        cyc();
        rd_chk("t5_cnt_dec", 14, 16'h0002);
        wr(14, 16'h0005);
        idle();
        rd_chk("t5_cnt_wr_wins", 14, 16'h0005);
        rd_chk("t5_stat_quiet", 11, 16'h0000);
        wr(10, 16'h0000);

        // T4/T6: sequencer (or its absence) and reset mid-stream
        wr(2, 16'h4400); wr(7, 16'h4410); wr(12, 16'h4420); wr(17, 16'h4430);
        wr(0, 16'h000D); wr(5, 16'h000D); wr(10, 16'h000D); wr(15, 16'h000D);
        wr(20, 16'h0001);
`ifdef HWBRK_SEQ_EN
        pc_hit("t4_out_of_order", 16'h4410, 0);
        rd_chk("t4_stage0", 20, 16'h0001);
        rd_chk("t4_stat1_clear", 6, 16'h0000);
        pc_hit("t4_link0", 16'h4400, 0);
        rd_chk("t4_stage1", 20, 16'h0101);
        pc_hit("t4_link1", 16'h4410, 0);
        pc_hit("t4_link2", 16'h4420, 0);
        rd_chk("t4_stage3", 20, 16'h0301);
        pc_hit("t4_last", 16'h4430, 1);
        rd_chk("t4_wrap", 20, 16'h0001);
        rd_chk("t4_stat3", 16, 16'h0001);
        pc_hit("t6_link0", 16'h4400, 0);
        rd_chk("t6_stage1", 20, 16'h0101);
`else
        rd_chk("seq_ctl_absent", 20, 16'h0000);
        pc_hit("indep_ch1", 16'h4410, 1);
`endif
        dbg_rst = 1; cyc(); dbg_rst = 0;
        check("t6_pnd", 32'(brk_pnd), 0);
        for (int a = 0; a <= 5*NCH; a++) rd_chk($sformatf("t6_reg%0d", a), a, 16'h0000);
        pc_hit("t6_no_halt_a", 16'h4400, 0);
        pc_hit("t6_no_halt_b", 16'h4430, 0);

        // random traffic against the model
        dbg_rst = 1; cyc(); dbg_rst = 0;
        model_reset();
        for (int i = 0; i < 800; i++) begin
            idle();
            brk_reg_wr = ($urandom_range(3) == 0);
            brk_reg_rd = 1'($urandom_range(1));
            if (brk_reg_wr) begin
                wa = int'($urandom_range(5*NCH));
                brk_reg_addr = AW'(wa);
                if (wa == 5*NCH)     dbg_din = 16'($urandom_range(1));
                else if (wa % 5 == 0) dbg_din = 16'($urandom_range(16'hFFFF));
                else if (wa % 5 == 1) dbg_din = 16'($urandom_range(16'hFFFF));
                else if (wa % 5 == 4) dbg_din = 16'($urandom_range(3));
                else                  dbg_din = 16'h4400 + 16'($urandom_range(3));
            end else begin
                brk_reg_addr = AW'($urandom_range((1 << AW) - 1));
            end
            decode_noirq = 1'($urandom_range(1));
            pc           = 16'h4400 + 16'($urandom_range(4));
            eu_mb_en     = 1'($urandom_range(1));
            eu_mab       = 16'h4400 + 16'($urandom_range(4));
            eu_mb_wr     = 2'($urandom_range(3));
            #1;
            model_comb();
            check("rnd_halt", 32'(brk_halt), 32'(e_halt));
            check("rnd_hit",  32'(brk_chan_hit), 32'(e_hit));
            check("rnd_pnd",  32'(brk_pnd), 32'(e_pnd));
            check("rnd_dout", 32'(brk_dout), 32'(e_dout));
            model_clk();
            cyc();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
